alu_seq: RTL

- Clocked, parametrised N-bit ALU; successor to the combinational seven-segment ALU.
- Adds an operand/opcode latch and a start/busy/done handshake.
- Adds iterative multi-cycle multiply, divide and modulo, plus registered status flags.
- Drives three hex seven-segment displays (operand A, operand B, result) on the lab board top level.

---
 rtl/alu_seq_pkg.sv | 32 +++
 rtl/alu_seq_hex_to_7seg.sv | 32 +++
 rtl/alu_seq.sv | 194 +++++++++++++++++++
 3 files changed

// File: rtl/alu_seq_pkg.sv
// Shared types and constants for the sequential ALU: opcodes, FSM states,
// seven-segment patterns and flag bit positions.
package alu_seq_pkg;

    typedef enum logic [3:0] {
        OpAdd = 4'b0000,
        OpSub = 4'b0001,
        OpAnd = 4'b0010,
        OpOr  = 4'b0011,
        OpXor = 4'b0100,
        OpShl = 4'b0101,
        OpShr = 4'b0110,
        OpMul = 4'b0111,
        OpDiv = 4'b1000,
        OpMod = 4'b1001
    } op_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        DONE = 2'd2
    } state_e;

    localparam logic [6:0] SEG_BLANK = 7'b1111111;
    localparam logic [6:0] SEG_ZERO  = 7'b1000000;

    localparam int unsigned FLAG_NEG = 3;
    localparam int unsigned FLAG_Z   = 2;
    localparam int unsigned FLAG_C   = 1;
    localparam int unsigned FLAG_V   = 0;

endpackage

// File: rtl/alu_seq_hex_to_7seg.sv
// Hex digit to active-low gfedcba seven-segment pattern, purely combinational.
module hex_to_7seg
    import alu_seq_pkg::*;
(
    input  logic [3:0] hex_i,
    output logic [6:0] seg_o
);

    always_comb begin
        seg_o = SEG_BLANK;
        case (hex_i)
            4'h0: seg_o = SEG_ZERO;
            4'h1: seg_o = 7'b1111001;
            4'h2: seg_o = 7'b0100100;
            4'h3: seg_o = 7'b0110000;
            4'h4: seg_o = 7'b0011001;
            4'h5: seg_o = 7'b0010010;
            4'h6: seg_o = 7'b0000010;
            4'h7: seg_o = 7'b1111000;
            4'h8: seg_o = 7'b0000000;
            4'h9: seg_o = 7'b0010000;
            4'hA: seg_o = 7'b0001000;
            4'hB: seg_o = 7'b0000011;
            4'hC: seg_o = 7'b1000110;
            4'hD: seg_o = 7'b0100001;
            4'hE: seg_o = 7'b0000110;
            4'hF: seg_o = 7'b0001110;
            default: seg_o = SEG_BLANK;
        endcase
    end

endmodule

// File: rtl/alu_seq.sv
// Clocked N-bit ALU with start/busy/done handshake, iterative MUL/DIV/MOD,
// registered flags and three hex seven-segment displays.
module alu_seq
    import alu_seq_pkg::*;
#(
    parameter int unsigned N     = 4,
    parameter int unsigned CNT_W = $clog2(N + 1)
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [N-1:0] A_num,
    input  logic [N-1:0] B_num,
    input  logic [3:0]   operation,
    input  logic         start,
    output logic         busy,
    output logic         done,
    output logic [N-1:0] result,
    output logic [3:0]   flags,
    output logic         err,
    output logic [6:0]   seg1,
    output logic [6:0]   seg2,
    output logic [6:0]   result_seg
);

    state_e           state_q, state_d;
    op_e              op_q, op_d;
    logic [N-1:0]     a_q, a_d, b_q, b_d;
    logic [N-1:0]     hi_q, hi_d, lo_q, lo_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [N-1:0]     result_q, result_d;
    logic [3:0]       flags_q, flags_d;
    logic             err_q, err_d, busy_q, busy_d, done_q, done_d;

    logic [N:0]   add_w, sub_w;
    logic [N:0]   mul_sum, div_sh, div_diff;
    logic [N-1:0] mul_hi, mul_lo, div_hi, div_lo;
    logic         div_ok;
    logic [N-1:0] res_w;
    logic         c_w, v_w, fin;

    assign add_w = {1'b0, A_num} + {1'b0, B_num};
    assign sub_w = {1'b0, A_num} - {1'b0, B_num};

    // MUL: hi:lo is the partial product, lo starts as the multiplier.
    assign mul_sum = {1'b0, hi_q} + (lo_q[0] ? {1'b0, b_q} : '0);
    assign mul_hi  = mul_sum[N:1];
    assign mul_lo  = {mul_sum[0], lo_q[N-1:1]};

    // DIV/MOD: hi is the remainder, lo shifts dividend out and quotient in.
    assign div_sh   = {hi_q, lo_q[N-1]};
    assign div_diff = div_sh - {1'b0, b_q};
    assign div_ok   = ~div_diff[N];
    assign div_hi   = div_ok ? div_diff[N-1:0] : div_sh[N-1:0];
    assign div_lo   = {lo_q[N-2:0], div_ok};

    always_comb begin
        state_d  = state_q;
        op_d     = op_q;
        a_d      = a_q;
        b_d      = b_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        cnt_d    = cnt_q;
        result_d = result_q;
        flags_d  = flags_q;
        err_d    = err_q;
        res_w    = '0;
        c_w      = 1'b0;
        v_w      = 1'b0;
        fin      = 1'b0;

        case (state_q)
            IDLE: begin
                if (start) begin
                    a_d     = A_num;
                    b_d     = B_num;
                    op_d    = op_e'(operation);
                    err_d   = 1'b0;
                    fin     = 1'b1;
                    state_d = DONE;
                    case (op_e'(operation))
                        OpAdd: begin
                            res_w = add_w[N-1:0];
                            c_w   = add_w[N];
                            v_w   = (A_num[N-1] == B_num[N-1]) && (add_w[N-1] != A_num[N-1]);
                        end
                        OpSub: begin
                            res_w = sub_w[N-1:0];
                            c_w   = sub_w[N];
                            v_w   = (A_num[N-1] != B_num[N-1]) && (sub_w[N-1] != A_num[N-1]);
                        end
                        OpAnd: res_w = A_num & B_num;
                        OpOr:  res_w = A_num | B_num;
                        OpXor: res_w = A_num ^ B_num;
                        OpShl: res_w = A_num << B_num[CNT_W-1:0];
                        OpShr: res_w = A_num >> B_num[CNT_W-1:0];
                        OpMul, OpDiv, OpMod: begin
                            if (operation != OpMul && B_num == '0) begin
                                res_w = (operation == OpDiv) ? '1 : A_num;
                                err_d = 1'b1;
                            end else begin
                                fin     = 1'b0;
                                state_d = EXEC;
                                cnt_d   = CNT_W'(N);
                                hi_d    = '0;
                                lo_d    = A_num;
                            end
                        end
                        default: begin
                            res_w = '0;
                            err_d = 1'b1;
                        end
                    endcase
                end
            end
            EXEC: begin
                cnt_d = cnt_q - CNT_W'(1);
                if (op_q == OpMul) begin
                    hi_d = mul_hi;
                    lo_d = mul_lo;
                end else begin
                    hi_d = div_hi;
                    lo_d = div_lo;
                end
                if (cnt_q == CNT_W'(1)) begin
                    fin     = 1'b1;
                    state_d = DONE;
                    case (op_q)
                        OpMul: begin
                            res_w = mul_lo;
                            c_w   = |mul_hi;
                        end
                        OpDiv:   res_w = div_lo;
                        default: res_w = div_hi;
                    endcase
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase

        if (fin) begin
            result_d          = res_w;
            flags_d[FLAG_NEG] = res_w[N-1];
            flags_d[FLAG_Z]   = (res_w == '0);
            flags_d[FLAG_C]   = c_w;
            flags_d[FLAG_V]   = v_w;
        end

        busy_d = (state_d != IDLE);
        done_d = (state_d == DONE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            op_q     <= OpAdd;
            a_q      <= '0;
            b_q      <= '0;
            hi_q     <= '0;
            lo_q     <= '0;
            cnt_q    <= '0;
            result_q <= '0;
            flags_q  <= '0;
            err_q    <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            op_q     <= op_d;
            a_q      <= a_d;
            b_q      <= b_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
            cnt_q    <= cnt_d;
            result_q <= result_d;
            flags_q  <= flags_d;
            err_q    <= err_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

    assign busy   = busy_q;
    assign done   = done_q;
    assign result = result_q;
    assign flags  = flags_q;
    assign err    = err_q;

    hex_to_7seg u_seg1 (.hex_i(a_q[3:0]),      .seg_o(seg1));
    hex_to_7seg u_seg2 (.hex_i(b_q[3:0]),      .seg_o(seg2));
    hex_to_7seg u_segr (.hex_i(result_q[3:0]), .seg_o(result_seg));

endmodule
